// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [2:0]           owner,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 err_clr
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int MX = GAP_CYCLES > BUSY_TIMEOUT ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [7:0]    win_data;
  logic [CW-1:0] cnt;
  int            d;
  int            best;
  // winner is the set request at the smallest distance past ptr
  always_comb begin
    win = ptr;
    win_data = 8'h00;
    best = NUM_REQ;
    d = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + 2 * NUM_REQ - int'(ptr) - 1) % NUM_REQ;
      if (req[i] && d < best) begin
        best = d;
        win = PW'(i);
        win_data = req_data[8*i +: 8];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= PW'(NUM_REQ - 1);
      cnt         <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      owner       <= 3'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          state    <= LAUNCH;
          tx_data  <= win_data;
          owner    <= 3'(win);
          ptr      <= win;
          ack      <= NUM_REQ'(1) << win;
          tx_start <= 1'b1;
          busy     <= 1'b1;
        end
        LAUNCH: begin
          state <= WAIT_BUSY;
          cnt   <= '0;
        end
        WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
          else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= GAP;
            cnt         <= '0;
          end else cnt <= cnt + 1'b1;
        WAIT_DONE: if (!tx_busy) begin
          state <= GAP;
          cnt   <= '0;
        end
        GAP: if (GAP_CYCLES == 0 || cnt == CW'(GAP_CYCLES - 1)) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else cnt <= cnt + 1'b1;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter (default build plus a GAP_CYCLES=0 build)
module tb_uart_tx_arbiter;
  localparam int N = 4, G = 16, BT = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req = '0, ack;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] tx_data;
  logic tx_start, tx_busy, busy, timeout_err, err_clr = 1'b0;
  logic [2:0] owner;
  logic [N-1:0] req_z = '0, ack_z;
  logic [8*N-1:0] req_data_z = '0;
  logic [7:0] tx_data_z;
  logic tx_start_z, tx_busy_z = 1'b0, busy_z, terr_z, err_clr_z = 1'b0;
  logic [2:0] owner_z;
  int n_cmp = 0, n_bad = 0, cyc = 0, last_start = 0;
  int busy_delay = 3, busy_len = 4, t = -1;
  logic tx_dead = 1'b0;
  logic [10:0] sb[$];
  logic [10:0] e;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(G), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .owner(owner),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr));

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0), .BUSY_TIMEOUT(BT)) dut_z (
    .clk(clk), .rst_n(rst_n), .req(req_z), .req_data(req_data_z), .ack(ack_z),
    .tx_data(tx_data_z), .tx_start(tx_start_z), .tx_busy(tx_busy_z), .owner(owner_z),
    .busy(busy_z), .timeout_err(terr_z), .err_clr(err_clr_z));

  always @(posedge clk) cyc <= cyc + 1;

  // transmitter model: raises tx_busy busy_delay edges after tx_start, for busy_len edges
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      t <= -1;
    end else if (tx_start && !tx_dead) t <= 1;
    else if (t > 0) begin
      t <= t + 1;
      if (t == busy_delay) tx_busy <= 1'b1;
      if (t == busy_delay + busy_len) begin
        tx_busy <= 1'b0;
        t <= -1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      if (sb.size() == 0) chk("unexpected_start", 32'(tx_start), 0);
      else begin
        e = sb.pop_front();
        chk("sb_ack", 32'(ack), 32'(1 << e[10:8]));
        chk("sb_owner", 32'(owner), 32'(e[10:8]));
        chk("sb_tx_data", 32'(tx_data), 32'(e[7:0]));
      end
    end
  end

  task automatic wait_start(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 1);
    req = req & ~ack;
  endtask

  task automatic wait_start_z(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_start_z) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    // single requester, byte latched and held
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    sb.push_back({3'd0, 8'hA5});
    wait_start("t1_start");
    req_data[7:0] = 8'h00;
    repeat (5) @(negedge clk);
    chk("t1_hold", 32'(tx_data), 32'hA5);
    chk("t1_busy", 32'(busy), 1);
    wait_idle("t1_idle");
    // all requesting: rotation from a fresh reset, with minimum spacing
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'hF;
    for (int k = 0; k < 5; k++) sb.push_back({3'(k % 4), 8'h10 + 8'(k % 4)});
    for (int k = 0; k < 5; k++) begin
      wait_start("t2_start");
      req = 4'hF;
      if (k > 0) chk("t2_spacing", 32'(cyc - last_start >= G + 3), 1);
      last_start = cyc;
    end
    req = 4'h0;
    wait_idle("t2_idle");
    // wrap search and ordering of a pair
    req_data[31:24] = 8'h33;
    req = 4'b1000;
    sb.push_back({3'd3, 8'h33});
    wait_start("t3_g3");
    wait_idle("t3_idle_a");
    req_data[23:16] = 8'h22;
    req = 4'b0100;
    sb.push_back({3'd2, 8'h22});
    wait_start("t3_g2");
    wait_idle("t3_idle_b");
    req_data[7:0] = 8'h0F;
    req_data[31:24] = 8'hF3;
    req = 4'b1001;
    sb.push_back({3'd3, 8'hF3});
    sb.push_back({3'd0, 8'h0F});
    wait_start("t3_pair_a");
    wait_start("t3_pair_b");
    wait_idle("t3_idle_c");
    // transmitter never starts
    tx_dead = 1'b1;
    req_data[15:8] = 8'h5A;
    req = 4'b0010;
    sb.push_back({3'd1, 8'h5A});
    wait_start("t4_start");
    repeat (BT) @(negedge clk);
    chk("t4_err_early", 32'(timeout_err), 0);
    @(negedge clk);
    chk("t4_err_set", 32'(timeout_err), 1);
    chk("t4_busy_gap", 32'(busy), 1);
    tx_dead = 1'b0;
    wait_idle("t4_idle_a");
    req_data[23:16] = 8'h77;
    req = 4'b0100;
    sb.push_back({3'd2, 8'h77});
    wait_start("t4_next");
    wait_idle("t4_idle_b");
    chk("t4_err_sticky", 32'(timeout_err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t4_err_clr", 32'(timeout_err), 0);
    // reset in the middle of a frame
    busy_len = 20;
    req_data[31:24] = 8'hC3;
    req = 4'b1000;
    sb.push_back({3'd3, 8'hC3});
    wait_start("t5_start");
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_txbusy_rise", 32'(ok), 1);
    @(negedge clk);
    chk("t5_in_frame", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_owner", 32'(owner), 0);
    chk("t5_tx_data", 32'(tx_data), 0);
    chk("t5_ack", 32'(ack), 0);
    chk("t5_tx_start", 32'(tx_start), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    busy_len = 4;
    req_data[7:0] = 8'h01;
    req_data[23:16] = 8'h21;
    req = 4'b0101;
    sb.push_back({3'd0, 8'h01});
    sb.push_back({3'd2, 8'h21});
    wait_start("t5_after_a");
    wait_start("t5_after_b");
    wait_idle("t5_idle");
    // zero-gap build: back-to-back frames, timeout colliding with err_clr
    req_data_z = {8'h00, 8'h00, 8'h22, 8'h11};
    req_z = 4'b0011;
    wait_start_z("t6_start_a");
    chk("t6_ack_a", 32'(ack_z), 32'b0001);
    chk("t6_data_a", 32'(tx_data_z), 32'h11);
    req_z = 4'b0010;
    @(negedge clk);
    tx_busy_z = 1'b1;
    repeat (2) @(negedge clk);
    tx_busy_z = 1'b0;
    @(negedge clk);
    chk("t6_gap_busy", 32'(busy_z), 1);
    chk("t6_gap_nostart", 32'(tx_start_z), 0);
    @(negedge clk);
    chk("t6_idle", 32'(busy_z), 0);
    @(negedge clk);
    chk("t6_start_b", 32'(tx_start_z), 1);
    chk("t6_ack_b", 32'(ack_z), 32'b0010);
    chk("t6_data_b", 32'(tx_data_z), 32'h22);
    chk("t6_owner_b", 32'(owner_z), 1);
    req_z = 4'b0000;
    repeat (BT) @(negedge clk);
    chk("t6_err_pre", 32'(terr_z), 0);
    err_clr_z = 1'b1;
    @(negedge clk);
    err_clr_z = 1'b0;
    chk("t6_err_collide", 32'(terr_z), 1);
    @(negedge clk);
    err_clr_z = 1'b1;
    @(negedge clk);
    err_clr_z = 1'b0;
    chk("t6_err_clr", 32'(terr_z), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
